// File: rtl/serial_fifo_controller.sv
// serial_fifo_controller: TX/RX FIFOs between the system bus and the board's
// CPLD UART. A single engine FSM drains TX and fills RX using the CPLD's
// uart_rdn/uart_wrn strobes. Build option: define SERIAL_IRQ_EN to add a
// registered irq output (pending RX data or a sticky error).
module serial_fifo_controller #(
  parameter int DATA_WIDTH    = 8,
  parameter int TX_DEPTH      = 16,
  parameter int RX_DEPTH      = 16,
  parameter int STROBE_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      write_op,
  input  logic                      read_op,
  input  logic [DATA_WIDTH-1:0]     bus_data_write,
  output logic [DATA_WIDTH-1:0]     bus_data_read,
  input  logic                      clr_err,
  output logic                      tx_full,
  output logic                      rx_empty,
  output logic [$clog2(TX_DEPTH):0] tx_count,
  output logic [$clog2(RX_DEPTH):0] rx_count,
  output logic                      tx_ovf,
  output logic                      rx_unf,
  output logic                      uart_rdn,
  output logic                      uart_wrn,
  input  logic                      uart_dataready,
  input  logic                      uart_tbre,
  input  logic                      uart_tsre,
  inout  wire  [DATA_WIDTH-1:0]     uart_data
`ifdef SERIAL_IRQ_EN
  ,
  output logic                      irq
`endif
);

  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam int TX_CW = TX_AW + 1;
  localparam int RX_CW = RX_AW + 1;
  localparam int SC_W  = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;

  localparam logic [TX_CW-1:0] TX_FULL_CNT = TX_CW'(TX_DEPTH);
  localparam logic [RX_CW-1:0] RX_FULL_CNT = RX_CW'(RX_DEPTH);
  localparam logic [SC_W-1:0]  SC_LAST     = SC_W'(STROBE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_STROBE,
    RD_DONE,
    WR_SETUP,
    WR_STROBE,
    WR_TBRE,
    WR_TSRE
  } state_t;

  // ---------------------------------------------------------------------
  // TX FIFO: bus pushes, engine pops
  // ---------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] tx_mem_q [TX_DEPTH];
  logic [TX_AW-1:0]      tx_wr_q, tx_wr_d;
  logic [TX_AW-1:0]      tx_rd_q, tx_rd_d;
  logic [TX_CW-1:0]      tx_cnt_q, tx_cnt_d;
  logic                  tx_push;
  logic                  tx_pop;
  logic [DATA_WIDTH-1:0] tx_head;

  // ---------------------------------------------------------------------
  // RX FIFO: engine pushes, bus pops
  // ---------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] rx_mem_q [RX_DEPTH];
  logic [RX_AW-1:0]      rx_wr_q, rx_wr_d;
  logic [RX_AW-1:0]      rx_rd_q, rx_rd_d;
  logic [RX_CW-1:0]      rx_cnt_q, rx_cnt_d;
  logic                  rx_push;
  logic                  rx_pop;

  // ---------------------------------------------------------------------
  // Engine and status registers
  // ---------------------------------------------------------------------
  state_t                state_q, state_d;
  logic [SC_W-1:0]       sc_q, sc_d;
  logic                  rdn_q, rdn_d;
  logic                  wrn_q, wrn_d;
  logic                  oe_q, oe_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  tx_ovf_q, tx_ovf_d;
  logic                  rx_unf_q, rx_unf_d;

  assign tx_full  = (tx_cnt_q == TX_FULL_CNT);
  assign rx_empty = (rx_cnt_q == '0);
  assign tx_count = tx_cnt_q;
  assign rx_count = rx_cnt_q;
  assign tx_ovf   = tx_ovf_q;
  assign rx_unf   = rx_unf_q;
  assign uart_rdn = rdn_q;
  assign uart_wrn = wrn_q;

  assign tx_push = write_op & ~tx_full;
  assign rx_pop  = read_op & ~rx_empty;
  assign tx_head = tx_mem_q[tx_rd_q];

  // Show-ahead read port; reads as zero while the RX FIFO is empty.
  assign bus_data_read = rx_empty ? '0 : rx_mem_q[rx_rd_q];

  // The CPLD data bus is only driven while a write strobe sequence is active.
  assign uart_data = oe_q ? dout_q : 'z;

  // TX pointer and occupancy next-state; a push and pop together leave the count unchanged.
  always_comb begin
    tx_wr_d  = tx_wr_q;
    tx_rd_d  = tx_rd_q;
    tx_cnt_d = tx_cnt_q;
    if (tx_push) tx_wr_d = tx_wr_q + 1'b1;
    if (tx_pop)  tx_rd_d = tx_rd_q + 1'b1;
    case ({tx_push, tx_pop})
      2'b10:   tx_cnt_d = tx_cnt_q + 1'b1;
      2'b01:   tx_cnt_d = tx_cnt_q - 1'b1;
      default: tx_cnt_d = tx_cnt_q;
    endcase
  end

  // RX pointer and occupancy next-state; a push and pop together leave the count unchanged.
  always_comb begin
    rx_wr_d  = rx_wr_q;
    rx_rd_d  = rx_rd_q;
    rx_cnt_d = rx_cnt_q;
    if (rx_push) rx_wr_d = rx_wr_q + 1'b1;
    if (rx_pop)  rx_rd_d = rx_rd_q + 1'b1;
    case ({rx_push, rx_pop})
      2'b10:   rx_cnt_d = rx_cnt_q + 1'b1;
      2'b01:   rx_cnt_d = rx_cnt_q - 1'b1;
      default: rx_cnt_d = rx_cnt_q;
    endcase
  end

  // TX storage: bus write port.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wr_q] <= bus_data_write;
  end

  // RX storage: captures the CPLD bus on the last cycle of a read strobe.
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem_q[rx_wr_q] <= uart_data;
  end

  // Sticky error flags: a new error in the same cycle as clr_err wins.
  always_comb begin
    tx_ovf_d = (write_op & tx_full)  | (tx_ovf_q & ~clr_err);
    rx_unf_d = (read_op  & rx_empty) | (rx_unf_q & ~clr_err);
  end

  // Serial engine next-state: RX has priority in IDLE so the CPLD is not overrun.
  always_comb begin
    state_d = state_q;
    sc_d    = sc_q;
    rdn_d   = rdn_q;
    wrn_d   = wrn_q;
    oe_d    = oe_q;
    dout_d  = dout_q;
    tx_pop  = 1'b0;
    rx_push = 1'b0;
    case (state_q)
      IDLE: begin
        if (uart_dataready && (rx_cnt_q != RX_FULL_CNT)) begin
          state_d = RD_STROBE;
          rdn_d   = 1'b0;
          sc_d    = '0;
        end else if (tx_cnt_q != '0) begin
          state_d = WR_SETUP;
          oe_d    = 1'b1;
          dout_d  = tx_head;
        end
      end
      RD_STROBE: begin
        if (sc_q == SC_LAST) begin
          rx_push = 1'b1;
          rdn_d   = 1'b1;
          state_d = RD_DONE;
        end else begin
          sc_d = sc_q + 1'b1;
        end
      end
      RD_DONE: begin
        state_d = IDLE;
      end
      WR_SETUP: begin
        state_d = WR_STROBE;
        wrn_d   = 1'b0;
        sc_d    = '0;
      end
      WR_STROBE: begin
        if (sc_q == SC_LAST) begin
          wrn_d   = 1'b1;
          oe_d    = 1'b0;
          tx_pop  = 1'b1;
          state_d = WR_TBRE;
        end else begin
          sc_d = sc_q + 1'b1;
        end
      end
      WR_TBRE: begin
        if (uart_tbre) state_d = WR_TSRE;
      end
      WR_TSRE: begin
        if (uart_tsre) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        rdn_d   = 1'b1;
        wrn_d   = 1'b1;
        oe_d    = 1'b0;
      end
    endcase
  end

  // State, pointers, counters and strobes; reset abandons any transfer in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sc_q     <= '0;
      rdn_q    <= 1'b1;
      wrn_q    <= 1'b1;
      oe_q     <= 1'b0;
      dout_q   <= '0;
      tx_wr_q  <= '0;
      tx_rd_q  <= '0;
      tx_cnt_q <= '0;
      rx_wr_q  <= '0;
      rx_rd_q  <= '0;
      rx_cnt_q <= '0;
      tx_ovf_q <= 1'b0;
      rx_unf_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sc_q     <= sc_d;
      rdn_q    <= rdn_d;
      wrn_q    <= wrn_d;
      oe_q     <= oe_d;
      dout_q   <= dout_d;
      tx_wr_q  <= tx_wr_d;
      tx_rd_q  <= tx_rd_d;
      tx_cnt_q <= tx_cnt_d;
      rx_wr_q  <= rx_wr_d;
      rx_rd_q  <= rx_rd_d;
      rx_cnt_q <= rx_cnt_d;
      tx_ovf_q <= tx_ovf_d;
      rx_unf_q <= rx_unf_d;
    end
  end

`ifdef SERIAL_IRQ_EN
  logic irq_q, irq_d;

  assign irq = irq_q;

  // Interrupt follows pending RX data or any sticky error, one cycle later.
  always_comb begin
    irq_d = (rx_cnt_q != '0) | tx_ovf_q | rx_unf_q;
  end

  // Interrupt register.
  always_ff @(posedge clk) begin
    if (rst) irq_q <= 1'b0;
    else     irq_q <= irq_d;
  end
`endif

endmodule

// File: doc/serial_fifo_controller.md
Name: serial_fifo_controller

Overview:
Parametrised CPLD UART controller with TX and RX FIFOs between the system bus and the board's CPLD serial chip.
- Bus side: single-cycle push/pop with no stall.
- Serial side: one FSM sequences uart_wrn/uart_rdn strobes against uart_dataready/uart_tbre/uart_tsre.
- The FSM drains TX and fills RX autonomously.
- Sits beside the bus decoder; shares uart_data with BaseRam.

Parameters:
DATA_WIDTH, 8, width of bus data and uart_data.
TX_DEPTH, 16, TX FIFO entries; power of two, at least 2.
RX_DEPTH, 16, RX FIFO entries; power of two, at least 2.
STROBE_CYCLES, 2, cycles uart_wrn/uart_rdn are held low; at least 1.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
write_op  in  1  push bus_data_write into TX FIFO
read_op  in  1  pop RX FIFO
bus_data_write  in  DATA_WIDTH  byte to transmit
bus_data_read  out  DATA_WIDTH  RX FIFO head (show-ahead)
clr_err  in  1  clears sticky error flags
tx_full  out  1  TX FIFO full
rx_empty  out  1  RX FIFO empty
tx_count  out  $clog2(TX_DEPTH)+1  TX occupancy
rx_count  out  $clog2(RX_DEPTH)+1  RX occupancy
tx_ovf  out  1  sticky: write_op while tx_full
rx_unf  out  1  sticky: read_op while rx_empty
uart_rdn  out  1  CPLD read strobe, active low
uart_wrn  out  1  CPLD write strobe, active low
uart_dataready  in  1  CPLD has a received byte
uart_tbre  in  1  CPLD transmit buffer empty
uart_tsre  in  1  CPLD transmit shift register empty
uart_data  inout  DATA_WIDTH  CPLD data bus

Behaviour:
- One clock: clk. rst is synchronous and active-high, sampled on posedge clk only.
- Reset values:
  - FIFOs are empty: tx_count=0, rx_count=0, rx_empty=1, tx_full=0.
  - tx_ovf=0, rx_unf=0.
  - uart_rdn=1, uart_wrn=1, uart_data is high-Z, FSM in IDLE.
  - bus_data_read=0 while empty.
- Reset during a strobe forces uart_rdn/uart_wrn high on the next edge. The partial transfer is discarded.
- Bus push/pop:
  - write_op with tx_full=0: push; count updates next cycle.
  - write_op with tx_full=1: no push; tx_ovf set.
  - read_op with rx_empty=0: bus_data_read shows the head combinationally; the pop takes effect at the edge.
  - read_op with rx_empty=1: no pop; rx_unf set.
  - clr_err clears both sticky flags. A simultaneous set wins.
  - Simultaneous bus push/pop and engine pop/push on the same FIFO are both honoured; the count is unchanged net.
- FSM states: IDLE, RD_STROBE, RD_DONE, WR_SETUP, WR_STROBE, WR_TBRE, WR_TSRE.
- IDLE:
  - if uart_dataready and rx_count<RX_DEPTH: go to RD_STROBE, uart_rdn<=0.
  - else if tx_count>0: go to WR_SETUP.
  - RX has priority to avoid CPLD overrun.
- RD_STROBE:
  - hold uart_rdn=0 for STROBE_CYCLES cycles.
  - on the last cycle, capture uart_data into the RX FIFO and set uart_rdn<=1.
  - then go to RD_DONE.
- RD_DONE: one idle turnaround cycle, then IDLE.
- WR_SETUP:
  - drive uart_data with the TX head; uart_wrn stays 1 for one cycle.
  - go to WR_STROBE with uart_wrn<=0.
- WR_STROBE:
  - uart_wrn=0 for STROBE_CYCLES cycles, data still driven.
  - at the end, uart_wrn<=1, pop TX, go to WR_TBRE.
- WR_TBRE: wait for uart_tbre=1, then WR_TSRE.
- WR_TSRE: wait for uart_tsre=1, then IDLE.
- uart_data is driven only in WR_SETUP and WR_STROBE; otherwise high-Z.
- Strobes are driven from registers (glitch-free).
- Counters wrap modulo depth on the pointers. Occupancy never exceeds depth.

Optional Feature:
SERIAL_IRQ_EN defined:
- Adds output irq (1 bit, registered, reset 0).
- irq=1 the cycle after rx_count becomes non-zero or either sticky error becomes set.
- irq clears when rx_empty=1 and both error flags are 0.

SERIAL_IRQ_EN undefined:
- No irq port and no logic; all other behaviour is identical.

Test Plan:
1. Reset, then push 0x41,0x42,0x43 with tbre/tsre tied 1 -> uart_data shows 0x41,0x42,0x43 in order during each 2-cycle uart_wrn low pulse, each preceded by a 1-cycle setup; tx_count returns 0.
2. CPLD model raises dataready with byte 0x5A -> uart_rdn low exactly 2 cycles, rx_count=1, bus_data_read=0x5A; read_op pops, rx_empty=1.
3. Push 17 bytes with tbre held 0 -> tx_full=1 at 16 entries (one was already popped into the write); 17th accepted or refused per count; an extra write while full sets tx_ovf; clr_err clears it.
4. Fill RX with 16 bytes, dataready stays 1 -> no further uart_rdn pulse until a read_op pops; then exactly one read follows.
5. dataready and a pending TX together in IDLE -> read serviced first, write starts after RD_DONE.
6. Assert rst mid-WR_STROBE -> next edge uart_wrn=1, uart_data high-Z, counts 0; with SERIAL_IRQ_EN, irq=0.
